// File: rtl/vec_mem_serializer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vmem_pkg: shared types and defaults for the vector memory serializer.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package vmem_pkg;

  localparam int VMEM_N      = 8;
  localparam int VMEM_R      = 6;
  localparam int VMEM_ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } vmem_state_t;

  // Lane k occupies bits [k*N +: N], the same layout as the CPU's ReadData/WriteData.
  typedef logic [VMEM_R-1:0][VMEM_N-1:0] lane_vec_t;

endpackage
`default_nettype wire

// File: rtl/vec_mem_serializer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vec_mem_serializer_if: CPU request/response and RAM port bundle.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface vec_mem_serializer_if
  import vmem_pkg::*;
#(
  parameter int I      = 32,
  parameter int N      = VMEM_N,
  parameter int R      = VMEM_R,
  parameter int ADDR_W = VMEM_ADDR_W
);
  logic              req_valid;
  logic              req_write;
  logic [I-1:0]      req_addr;
  logic [R*N-1:0]    req_wdata;
  logic              req_ready;
  logic              stall;
  logic              rsp_valid;
  logic [R*N-1:0]    rsp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [N-1:0]      mem_wdata;
  logic [N-1:0]      mem_rdata;
  logic              err;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_rdata,
    output req_ready, stall, rsp_valid, rsp_rdata, mem_addr, mem_we, mem_wdata, err
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_rdata,
    input  req_ready, stall, rsp_valid, rsp_rdata, mem_addr, mem_we, mem_wdata, err
  );
endinterface
`default_nettype wire

// File: rtl/vec_mem_serializer_lane_assembler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vmem_lane_assembler: R-lane read capture register, one lane per write.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vmem_lane_assembler
  import vmem_pkg::*;
#(
  parameter int N     = VMEM_N,
  parameter int R     = VMEM_R,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_cap_en,
  input  logic [IDX_W-1:0] i_cap_idx,
  input  logic [N-1:0]     i_cap_data,
  output logic [R*N-1:0]   o_lanes
);

  logic [R-1:0][N-1:0] r_lanes;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lanes <= '0;
    end else if (i_clr) begin
      r_lanes <= '0;
    end else if (i_cap_en) begin
      r_lanes[i_cap_idx] <= i_cap_data;
    end
  end

  assign o_lanes = r_lanes;

endmodule
`default_nettype wire

// File: rtl/vec_mem_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vec_mem_serializer: splits an R-lane vector load/store into R byte RAM   |
// | accesses. Optional VMEM_BOUNDS_CHECK_EN rejects out-of-range requests.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vec_mem_serializer
  import vmem_pkg::*;
#(
  parameter int I      = 32,
  parameter int N      = VMEM_N,
  parameter int R      = VMEM_R,
  parameter int ADDR_W = VMEM_ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  vec_mem_serializer_if.slave  bus
);

  localparam int              CNT_W  = (R > 1) ? $clog2(R) : 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(R - 1);

  vmem_state_t         r_state;
  vmem_state_t         w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_base;
  logic [R-1:0][N-1:0] r_wvec;
  logic                r_rsp_valid;
  logic                r_err;

  logic                w_accept;
  logic                w_reject;
  logic                w_start;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [N-1:0]        w_mem_wdata;
  logic                w_cap_en;
  logic [CNT_W-1:0]    w_cap_idx;
  logic [R*N-1:0]      w_rdata;

`ifdef VMEM_BOUNDS_CHECK_EN
  logic [ADDR_W:0] w_end;
  assign w_end    = {1'b0, bus.req_addr[ADDR_W-1:0]} + (ADDR_W + 1)'(R - 1);
  assign w_reject = (|bus.req_addr[I-1:ADDR_W]) | w_end[ADDR_W];
`else
  logic w_unused;
  assign w_unused = ^bus.req_addr[I-1:ADDR_W];
  assign w_reject = 1'b0;
`endif

  assign w_accept = bus.req_valid & (r_state == IDLE);
  assign w_start  = w_accept & ~w_reject;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_base      <= '0;
      r_wvec      <= '0;
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rsp_valid <= (r_state == DRAIN);
      r_err       <= w_accept & w_reject;
      if (w_start) begin
        r_base <= bus.req_addr[ADDR_W-1:0];
        r_wvec <= bus.req_wdata;
        r_cnt  <= '0;
      end else if (r_state == WRITE || r_state == READ) begin
        r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_cap_en    = 1'b0;
    w_cap_idx   = '0;
    case (r_state)
      IDLE: begin
        if (w_start) w_state_nxt = bus.req_write ? WRITE : READ;
      end
      WRITE: begin
        w_mem_we    = 1'b1;
        w_mem_addr  = r_base + ADDR_W'(r_cnt);
        w_mem_wdata = r_wvec[r_cnt];
        if (r_cnt == c_last) w_state_nxt = IDLE;
      end
      READ: begin
        w_mem_addr = r_base + ADDR_W'(r_cnt);
        // RAM answers one cycle late, so the capture trails the address by one lane.
        w_cap_en   = (r_cnt != '0);
        w_cap_idx  = r_cnt - 1'b1;
        if (r_cnt == c_last) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        w_cap_en    = 1'b1;
        w_cap_idx   = c_last;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  vmem_lane_assembler #(
    .N     (N),
    .R     (R),
    .IDX_W (CNT_W)
  ) u_assembler (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (1'b0),
    .i_cap_en   (w_cap_en),
    .i_cap_idx  (w_cap_idx),
    .i_cap_data (bus.mem_rdata),
    .o_lanes    (w_rdata)
  );

  assign bus.req_ready = (r_state == IDLE);
  assign bus.stall     = (r_state != IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = w_rdata;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_vec_mem_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vec_mem_serializer: randomized scoreboard bench with a byte-array     |
// | reference memory.                                                        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_vec_mem_serializer;
  import vmem_pkg::*;

  localparam int I      = 32;
  localparam int N      = 8;
  localparam int R      = 6;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vec_mem_serializer_if #(.I(I), .N(N), .R(R), .ADDR_W(ADDR_W)) bus ();

  vec_mem_serializer #(.I(I), .N(N), .R(R), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct { int cyc; logic [ADDR_W-1:0] a; logic [N-1:0] d; } wr_exp_t;
  typedef struct { int cyc; logic [R*N-1:0] d; } rd_exp_t;

  wr_exp_t        wq[$];
  rd_exp_t        rq[$];
  int             eq[$];
  wr_exp_t        ew;
  rd_exp_t        er;
  int             ee;
  bit [N-1:0]     ram[DEPTH];
  bit [N-1:0]     ref_mem[DEPTH];
  int             pcyc = 0;
  int             total = 0;
  int             bad = 0;
  int             exp_ready_cyc = -1;
  int             held_cyc = -1;
  logic [R*N-1:0] held_val = '0;

  always @(posedge clk) pcyc <= pcyc + 1;

  // Registered single-port byte RAM
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, pcyc);
    end
  endtask

  function automatic bit rejects(input logic [I-1:0] a);
    bit oob;
    oob = (a[I-1:ADDR_W] != 0) || (int'(a[ADDR_W-1:0]) + R - 1 > DEPTH - 1);
`ifdef VMEM_BOUNDS_CHECK_EN
    return oob;
`else
    return oob & 1'b0;
`endif
  endfunction

  task automatic check_reset_outputs();
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_stall",     bus.stall,     0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_mem_addr",  bus.mem_addr,  0);
    check("rst_mem_we",    bus.mem_we,    0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_err",       bus.err,       0);
  endtask

  // Monitor: every DUT-presented event pops the oldest matching expectation.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.mem_we) begin
        if (wq.size() == 0) check("unexpected_write", bus.mem_we, 0);
        else begin
          ew = wq.pop_front();
          check("write_cycle", pcyc, ew.cyc);
          check("write_addr", bus.mem_addr, ew.a);
          check("write_data", bus.mem_wdata, ew.d);
        end
      end
      if (bus.rsp_valid) begin
        if (rq.size() == 0) check("unexpected_rsp", bus.rsp_valid, 0);
        else begin
          er = rq.pop_front();
          check("rsp_cycle", pcyc, er.cyc);
          check("rsp_rdata", bus.rsp_rdata, er.d);
          held_cyc = pcyc + 1;
          held_val = er.d;
        end
      end
      if (bus.err) begin
        if (eq.size() == 0) check("unexpected_err", bus.err, 0);
        else begin
          ee = eq.pop_front();
          check("err_cycle", pcyc, ee);
        end
      end
      if (pcyc == held_cyc) check("rdata_hold", bus.rsp_rdata, held_val);
    end
  end

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic do_req(input bit wr, input logic [I-1:0] addr, input logic [R*N-1:0] wd,
                        input bit jitter);
    int                start;
    int                guard;
    int                acc;
    logic [ADDR_W-1:0] a;
    lane_vec_t         v;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    start = pcyc;
    guard = 0;
    while (!bus.req_ready && guard < 40) begin
      @(negedge clk);
      guard++;
      if (jitter && !bus.req_ready) bus.req_addr = I'($urandom_range(0, DEPTH - R));
    end
    if (!bus.req_ready) begin
      check("ready_timeout", bus.req_ready, 1);
      bus.req_valid = 1'b0;
      return;
    end
    if (exp_ready_cyc >= 0 && start <= exp_ready_cyc) check("ready_cycle", pcyc, exp_ready_cyc);
    acc = pcyc + 1;
    a   = bus.req_addr[ADDR_W-1:0];
    if (rejects(bus.req_addr)) begin
      eq.push_back(acc);
      exp_ready_cyc = acc;
    end else if (wr) begin
      for (int k = 0; k < R; k++) begin
        ref_mem[a + ADDR_W'(k)] = wd[k*N +: N];
        wq.push_back('{acc + k, a + ADDR_W'(k), wd[k*N +: N]});
      end
      exp_ready_cyc = acc + R;
    end else begin
      for (int k = 0; k < R; k++) v[k] = ref_mem[a + ADDR_W'(k)];
      rq.push_back('{acc + R + 1, v});
      exp_ready_cyc = acc + R + 1;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = (R*N)'({$urandom, $urandom});
  endtask

  initial begin
    logic [I-1:0] ra;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset = 1'b1;
    @(negedge clk);

    do_req(1'b1, 32'h10, 48'h665544332211, 1'b0);
    do_req(1'b0, 32'h10, '0, 1'b0);
    do_req(1'b0, 32'h20, '0, 1'b0);
    do_req(1'b1, 32'h3FE, 48'hA5A4A3A2A1A0, 1'b0);
    do_req(1'b0, 32'h3FE, '0, 1'b0);
    do_req(1'b0, 32'h0, '0, 1'b0);
    do_req(1'b1, 32'h0001_0020, 48'hF5F4F3F2F1F0, 1'b0);
    do_req(1'b0, 32'h20, '0, 1'b0);

    do_req(1'b1, 32'h100, 48'h0102_0304_0506, 1'b0);
    do_req(1'b0, 32'h100, '0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      case ($urandom_range(0, 3))
        0, 1:    ra = I'($urandom_range(0, DEPTH - 1));
        2:       ra = I'(DEPTH - 1 - $urandom_range(0, 7));
        default: ra = $urandom;
      endcase
      do_req(1'($urandom_range(0, 1)), ra, (R*N)'({$urandom, $urandom}), 1'b0);
    end

    do_req(1'b0, 32'h10, '0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    rq.delete();
    exp_ready_cyc = -1;
    held_cyc = -1;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_req(1'b0, 32'h10, '0, 1'b0);
    do_req(1'b0, 32'h3FE, '0, 1'b0);

    for (int g = 0; g < 50 && (wq.size() + rq.size() + eq.size()) != 0; g++) @(negedge clk);
    check("pending_writes", wq.size(), 0);
    check("pending_rsps", rq.size(), 0);
    check("pending_errs", eq.size(), 0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
